// File: rtl/game_tick_if.sv
// Bus between the pixel/control side and the game tick generator.
// Signal names keep the i_/o_ sense as seen from the generator.
interface game_tick_if #(
    parameter int NUM_CH    = 2,
    parameter int DIV_WIDTH = 4,
    parameter int CNT_WIDTH = 16
);
    // No valid/ready pair here: i_step and i_div_load are single-cycle strobes
    // acted on in the clock they are high; outputs are registered level pulses.
    logic [9:0]                  i_x;
    logic [9:0]                  i_y;
    logic                        i_enable;
    logic                        i_step;
    logic [NUM_CH*DIV_WIDTH-1:0] i_div;
    logic                        i_div_load;
    logic                        o_frame_pulse;
    logic [NUM_CH-1:0]           o_tick;
    logic [CNT_WIDTH-1:0]        o_tick_count;

    modport master (
        output i_x, i_y, i_enable, i_step, i_div, i_div_load,
        input  o_frame_pulse, o_tick, o_tick_count
    );

    modport slave (
        input  i_x, i_y, i_enable, i_step, i_div, i_div_load,
        output o_frame_pulse, o_tick, o_tick_count
    );
endinterface

// File: rtl/game_tick_gen.sv
// Frame-locked multi-channel game tick generator with runtime divisors,
// pause / single-step control and a channel-0 tick counter.
module game_tick_gen #(
    parameter int MAX_H_ADDR  = 639,
    parameter int MAX_V_ADDR  = 479,
    parameter int NUM_CH      = 2,
    parameter int DIV_WIDTH   = 4,
    parameter int DEFAULT_DIV = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    game_tick_if.slave bus
);
    logic                 match;
    logic                 match_d;
    logic                 eof;
    logic                 step_go;
    logic                 load_pending;
    logic                 step_pending;
    logic                 frame_pulse_q;
    logic [NUM_CH-1:0]    tick_q;
    logic [CNT_WIDTH-1:0] tick_count_q;
    logic [DIV_WIDTH-1:0] active_div  [NUM_CH];
    logic [DIV_WIDTH-1:0] pending_div [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt         [NUM_CH];

    // match_d resets high so coordinates parked on the last pixel at reset
    // release do not produce a frame end.
    always_comb begin
        match   = (bus.i_x == 10'(MAX_H_ADDR)) && (bus.i_y == 10'(MAX_V_ADDR));
        eof     = match & ~match_d;
        step_go = step_pending & ~bus.i_enable;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            match_d       <= 1'b1;
            frame_pulse_q <= 1'b0;
            tick_q        <= '0;
            tick_count_q  <= '0;
            load_pending  <= 1'b0;
            step_pending  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                active_div[c]  <= DIV_WIDTH'(DEFAULT_DIV);
                pending_div[c] <= DIV_WIDTH'(DEFAULT_DIV);
                cnt[c]         <= '0;
            end
        end else begin
            match_d       <= match;
            frame_pulse_q <= eof;

            if (eof) load_pending <= 1'b0;
            // A load on the eof clock is queued for the following frame end.
            if (bus.i_div_load) begin
                load_pending <= 1'b1;
                for (int c = 0; c < NUM_CH; c++)
                    pending_div[c] <= bus.i_div[c*DIV_WIDTH +: DIV_WIDTH];
            end

            if (bus.i_enable)    step_pending <= 1'b0;
            else if (bus.i_step) step_pending <= 1'b1;
            else if (eof)        step_pending <= 1'b0;

            if (tick_q[0]) tick_count_q <= tick_count_q + 1'b1;

            for (int c = 0; c < NUM_CH; c++) begin
                tick_q[c] <= 1'b0;
                if (eof) begin
                    if (load_pending) begin
                        active_div[c] <= pending_div[c];
                        cnt[c]        <= '0;
                        tick_q[c]     <= step_go;
                    end else if (!bus.i_enable) begin
                        if (step_go) begin
                            tick_q[c] <= 1'b1;
                            cnt[c]    <= '0;
                        end
                    end else if (cnt[c] == active_div[c]) begin
                        tick_q[c] <= 1'b1;
                        cnt[c]    <= '0;
                    end else begin
                        cnt[c] <= cnt[c] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_frame_pulse = frame_pulse_q;
    assign bus.o_tick        = tick_q;
    assign bus.o_tick_count  = tick_count_q;
endmodule
